// File: rtl/fetch_cntrl_burst.sv
// fetch_cntrl_burst: credit-based burst read controller feeding a DEPTH-entry output FIFO.
// Define FETCH_BURST_EN for multi-beat bursts; otherwise every request is a single beat.
module fetch_cntrl_burst #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int LW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  output logic          req_rdy,
  output logic          ram_rden,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic          out_vld,
  output logic [DW-1:0] out_pl,
  output logic          out_last,
  input  logic          out_rdy,
  output logic          busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t        state;
  logic [AW-1:0] cur;
  logic [DW:0]   mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [OW-1:0] occ;
  logic          inflight, inflight_last, issue, pop, last;
`ifdef FETCH_BURST_EN
  logic [LW-1:0] rem;
  assign last = rem == '0;
`else
  logic unused_len;
  assign unused_len = ^req_len;
  assign last = 1'b1;
`endif
  // Credit counts the read in flight but not a same-cycle pop, so nothing combinational from out_rdy
  assign issue    = state == BURST && (occ + OW'(inflight)) < OW'(DEPTH);
  assign req_rdy  = state == IDLE;
  assign ram_rden = issue;
  assign ram_addr = cur;
  assign out_vld  = occ != '0;
  assign pop      = out_vld & out_rdy;
  assign {out_last, out_pl} = mem[rp];
  assign busy     = state == BURST || inflight || out_vld;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wp            <= '0;
      rp            <= '0;
      occ           <= '0;
`ifdef FETCH_BURST_EN
      rem           <= '0;
`endif
    end else begin
      inflight      <= issue;
      inflight_last <= last;
      if (state == IDLE && req_vld) begin
        state <= BURST;
        cur   <= req_addr;
`ifdef FETCH_BURST_EN
        rem   <= req_len;
`endif
      end else if (issue) begin
        cur <= cur + 1'b1;
`ifdef FETCH_BURST_EN
        rem <= rem - 1'b1;
`endif
        if (last) state <= IDLE;
      end
      if (inflight) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      occ <= occ + OW'(inflight) - OW'(pop);
    end
  end
  always_ff @(posedge clk) if (inflight) mem[wp] <= {inflight_last, ram_dout};
  always_ff @(posedge clk) if (!rst) assert (!(inflight && occ == OW'(DEPTH)));
endmodule

// File: tb/tb_fetch_cntrl_burst.sv
// tb_fetch_cntrl_burst: directed checks of latency, bursts, backpressure, wrap and reset.
module tb_fetch_cntrl_burst;
  localparam int DEPTH = 4;
`ifdef FETCH_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic        clk = 0, rst = 1, req_vld = 0, out_rdy = 1;
  logic [7:0]  req_addr = 0;
  logic [3:0]  req_len = 0;
  logic        req_rdy, ram_rden, out_vld, out_last, busy;
  logic [7:0]  ram_addr;
  logic [31:0] ram_dout = 0, out_pl;
  int n_vec = 0, n_err = 0, first_cyc, last_cyc, cnt;

  fetch_cntrl_burst #(.AW(8), .DW(32), .LW(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr), .req_len(req_len),
    .req_rdy(req_rdy), .ram_rden(ram_rden), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .out_vld(out_vld), .out_pl(out_pl), .out_last(out_last), .out_rdy(out_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [7:0] a);
    return {16'hC0DE, ~a, a};
  endfunction

  always @(posedge clk) if (ram_rden) ram_dout <= f(ram_addr);

  function automatic int nbeats(input int len);
    return BURST ? len + 1 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [3:0] l);
    req_vld = 1; req_addr = a; req_len = l;
    chk("req_rdy_before", req_rdy, 1);
    @(negedge clk);
    req_vld = 0;
  endtask

  task automatic drain(input logic [7:0] base, input int nb);
    int k = 0, cyc = 0;
    while (k < nb && cyc < 200) begin
      if (out_vld && out_rdy) begin
        chk("beat_pl", out_pl, f(8'(base + k)));
        chk("beat_last", out_last, k == nb - 1);
        if (k == 0) first_cyc = cyc;
        last_cyc = cyc;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("beat_count", k, nb);
    chk("drained_vld", out_vld, 0);
    chk("drained_busy", busy, 0);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_rden", ram_rden, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);
    // 1: single beat latency
    send(8'h10, 0);
    chk("t1_rden", ram_rden, 1);
    chk("t1_addr", ram_addr, 8'h10);
    chk("t1_rdy_low", req_rdy, 0);
    chk("t1_vld0", out_vld, 0);
    @(negedge clk);
    chk("t1_rden_off", ram_rden, 0);
    chk("t1_rdy_back", req_rdy, 1);
    chk("t1_busy_inflight", busy, 1);
    chk("t1_vld1", out_vld, 0);
    @(negedge clk);
    chk("t1_vld", out_vld, 1);
    chk("t1_pl", out_pl, f(8'h10));
    chk("t1_last", out_last, 1);
    drain(8'h10, 1);
    // 2: full-throughput burst
    send(8'h20, 7);
    drain(8'h20, nbeats(7));
    chk("t2_thru", last_cyc - first_cyc, nbeats(7) - 1);
    // 3: backpressure fills exactly the FIFO, then releases in order
    out_rdy = 0;
    send(8'h50, 15);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cnt += int'(ram_rden);
      @(negedge clk);
    end
    chk("t3_issued", cnt, nbeats(15) < DEPTH ? nbeats(15) : DEPTH);
    chk("t3_rden_stop", ram_rden, 0);
    chk("t3_vld", out_vld, 1);
    chk("t3_pl0", out_pl, f(8'h50));
    @(negedge clk); @(negedge clk);
    chk("t3_pl_stable", out_pl, f(8'h50));
    chk("t3_last_stable", out_last, nbeats(15) == 1);
    out_rdy = 1;
    drain(8'h50, nbeats(15));
    // 4: address wrap
    send(8'hFE, 3);
    drain(8'hFE, nbeats(3));
    // 5: reset mid-burst, then a clean burst
    send(8'h60, 7);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t5_vld", out_vld, 0);
    chk("t5_busy", busy, 0);
    chk("t5_req_rdy", req_rdy, 1);
    rst = 0;
    send(8'h40, 1);
    drain(8'h40, nbeats(1));
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cnt += int'(ram_rden) + int'(out_vld);
      @(negedge clk);
    end
    chk("t5_no_extra", cnt, 0);
    // 6: request length honoured only in burst builds
    send(8'h30, 5);
    chk("t6_rden", ram_rden, 1);
    chk("t6_addr", ram_addr, 8'h30);
    chk("t6_rdy_low", req_rdy, 0);
    @(negedge clk);
    chk("t6_rdy_t2", req_rdy, !BURST);
    drain(8'h30, nbeats(5));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
